// File: rtl/cfg_pkg.sv
// cfg_pkg: shared definitions for the configuration write path.
//   - default address/data widths of the config write ports
//   - address map of the five-entry PWM/output configuration bank
//   - cfg_wr_t write record {addr, data}
//   - port selector enum used by the round-robin arbiter
//   - saturating increment helper for the error counter
package cfg_pkg;

  localparam int CFG_ADDR_W   = 7;
  localparam int CFG_DATA_W   = 8;
  localparam int NUM_CFG_REGS = 5;
  localparam int ERR_CNT_W    = 8;

  localparam logic [CFG_ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [CFG_ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [CFG_ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [CFG_ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [CFG_ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

  // Index of each register inside the bank array.
  localparam int IDX_EN_OUT_LO = 0;
  localparam int IDX_EN_OUT_HI = 1;
  localparam int IDX_EN_PWM_LO = 2;
  localparam int IDX_EN_PWM_HI = 3;
  localparam int IDX_PWM_DUTY  = 4;

  typedef struct packed {
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
  } cfg_wr_t;

  typedef enum logic {
    GRANT_P0 = 1'b0,
    GRANT_P1 = 1'b1
  } port_sel_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cfg_wr_fifo.sv
// cfg_wr_fifo: small synchronous FIFO holding queued config writes of one port.
//   clk, rst_n      clock, asynchronous active-low reset (empties the FIFO)
//   push_i, wdata_i write side; a push into a full FIFO is ignored
//   pop_i, rdata_o  read side; rdata_o is the current head (valid when !empty_o)
//   count_o         registered occupancy
//   full_o, empty_o registered status, derived from count only
module cfg_wr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 15,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when it pops in the same cycle, so that
  // the ready seen by the requester never depends on this cycle's pop.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cfg_write_arbiter.sv
// cfg_write_arbiter: two-port write arbiter in front of the PWM/output
// configuration register bank.
//   clk, rst_n                   clock, asynchronous active-low reset
//   p0_valid/ready/addr/data     port 0 (SPI frame decoder) write request
//   p1_valid/ready/addr/data     port 1 (sequencer / debug master) write request
//   clr_err                      one-cycle clear of addr_err and err_cnt
//   en_reg_out_7_0 .. pwm_duty_cycle   configuration register outputs
//   addr_err                     sticky: a write to an unmapped address was dropped
//   err_cnt                      saturating count of dropped writes
//   busy                         at least one port FIFO holds a write
// Each port queues into its own FIFO; a round-robin arbiter commits at most
// one write per cycle into the bank.
module cfg_write_arbiter
  import cfg_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = CFG_ADDR_W,
  parameter int DATA_W     = CFG_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  input  logic              clr_err,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              addr_err,
  output logic [7:0]        err_cnt,
  output logic              busy
);

  localparam int WR_W  = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [WR_W-1:0]   f0_rdata, f1_rdata;
  logic [CNT_W-1:0]  f0_count, f1_count;
  logic              f0_full, f1_full;
  logic              f0_empty, f1_empty;
  logic              gnt0, gnt1, commit;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  port_sel_e         last_grant_q, last_grant_d;

  logic [DATA_W-1:0]       cfg_q [NUM_CFG_REGS];
  logic [NUM_CFG_REGS-1:0] reg_we;
  logic                    bad_commit;

  logic                 addr_err_q, addr_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Ready comes straight from the registered full flag.
  assign p0_ready = !f0_full;
  assign p1_ready = !f1_full;

  cfg_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WR_W),
    .CNT_W (CNT_W)
  ) u_fifo_p0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (p0_valid),
    .wdata_i ({p0_addr, p0_data}),
    .pop_i   (gnt0),
    .rdata_o (f0_rdata),
    .count_o (f0_count),
    .full_o  (f0_full),
    .empty_o (f0_empty)
  );

  cfg_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WR_W),
    .CNT_W (CNT_W)
  ) u_fifo_p1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (p1_valid),
    .wdata_i ({p1_addr, p1_data}),
    .pop_i   (gnt1),
    .rdata_o (f1_rdata),
    .count_o (f1_count),
    .full_o  (f1_full),
    .empty_o (f1_empty)
  );

  // Round-robin: under contention the port that did not win last is granted.
  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    last_grant_d = last_grant_q;
    if (!f0_empty && !f1_empty) begin
      if (last_grant_q == GRANT_P1) gnt0 = 1'b1;
      else                          gnt1 = 1'b1;
    end else if (!f0_empty) begin
      gnt0 = 1'b1;
    end else if (!f1_empty) begin
      gnt1 = 1'b1;
    end
    if (gnt0) last_grant_d = GRANT_P0;
    if (gnt1) last_grant_d = GRANT_P1;
  end

  assign commit                 = gnt0 || gnt1;
  assign {head_addr, head_data} = gnt1 ? f1_rdata : f0_rdata;

  // Address decode of the committed head entry.
  always_comb begin
    reg_we     = '0;
    bad_commit = 1'b0;
    if (commit) begin
      case (head_addr)
        ADDR_W'(ADDR_EN_OUT_LO): reg_we[IDX_EN_OUT_LO] = 1'b1;
        ADDR_W'(ADDR_EN_OUT_HI): reg_we[IDX_EN_OUT_HI] = 1'b1;
        ADDR_W'(ADDR_EN_PWM_LO): reg_we[IDX_EN_PWM_LO] = 1'b1;
        ADDR_W'(ADDR_EN_PWM_HI): reg_we[IDX_EN_PWM_HI] = 1'b1;
        ADDR_W'(ADDR_PWM_DUTY):  reg_we[IDX_PWM_DUTY]  = 1'b1;
        default:                 bad_commit            = 1'b1;
      endcase
    end
  end

  // A clear coinciding with a dropped write keeps that drop recorded.
  always_comb begin
    addr_err_d = addr_err_q;
    err_cnt_d  = err_cnt_q;
    if (clr_err) begin
      addr_err_d = bad_commit;
      err_cnt_d  = bad_commit ? ERR_CNT_W'(1) : '0;
    end else if (bad_commit) begin
      addr_err_d = 1'b1;
      err_cnt_d  = sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_P1;
      addr_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      addr_err_q   <= addr_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // The bank is reset as well: downstream PWM must see all-zero config.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CFG_REGS; i++) cfg_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CFG_REGS; i++) begin
        if (reg_we[i]) cfg_q[i] <= head_data;
      end
    end
  end

  assign en_reg_out_7_0  = cfg_q[IDX_EN_OUT_LO];
  assign en_reg_out_15_8 = cfg_q[IDX_EN_OUT_HI];
  assign en_reg_pwm_7_0  = cfg_q[IDX_EN_PWM_LO];
  assign en_reg_pwm_15_8 = cfg_q[IDX_EN_PWM_HI];
  assign pwm_duty_cycle  = cfg_q[IDX_PWM_DUTY];

  assign addr_err = addr_err_q;
  assign err_cnt  = err_cnt_q;
  // Derived only from registered occupancy.
  assign busy     = (f0_count != '0) || (f1_count != '0);

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Testbench for cfg_write_arbiter: table-driven cycle vectors plus directed
// sequences for error saturation, mid-operation reset and clear collisions.
module tb_cfg_write_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       p0_valid, p1_valid, clr_err;
  logic       p0_ready, p1_ready;
  logic [6:0] p0_addr, p1_addr;
  logic [7:0] p0_data, p1_data;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       addr_err, busy;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfg_write_arbiter #(
    .FIFO_DEPTH (2),
    .ADDR_W     (7),
    .DATA_W     (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .p0_valid        (p0_valid),
    .p0_ready        (p0_ready),
    .p0_addr         (p0_addr),
    .p0_data         (p0_data),
    .p1_valid        (p1_valid),
    .p1_ready        (p1_ready),
    .p1_addr         (p1_addr),
    .p1_data         (p1_data),
    .clr_err         (clr_err),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .addr_err        (addr_err),
    .err_cnt         (err_cnt),
    .busy            (busy)
  );

  typedef struct {
    logic       rst;
    logic       v0;
    logic [6:0] a0;
    logic [7:0] d0;
    logic       v1;
    logic [6:0] a1;
    logic [7:0] d1;
    logic [7:0] e_lo, e_hi, e_plo, e_phi, e_duty;
    logic       e_err;
    logic [7:0] e_cnt;
    logic       e_busy, e_r0, e_r1;
  } vec_t;

  localparam int NVEC = 16;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic rst, input logic v0, input logic [6:0] a0,
                              input logic [7:0] d0, input logic v1, input logic [6:0] a1,
                              input logic [7:0] d1, input logic [7:0] lo, input logic [7:0] hi,
                              input logic [7:0] plo, input logic [7:0] phi, input logic [7:0] duty,
                              input logic err, input logic [7:0] cnt, input logic bsy,
                              input logic r0, input logic r1);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.e_lo = lo; v.e_hi = hi; v.e_plo = plo; v.e_phi = phi; v.e_duty = duty;
    v.e_err = err; v.e_cnt = cnt; v.e_busy = bsy; v.e_r0 = r0; v.e_r1 = r1;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_bank(input int idx, input logic [7:0] lo, input logic [7:0] hi,
                          input logic [7:0] plo, input logic [7:0] phi, input logic [7:0] duty);
    chk("en_reg_out_7_0",  idx, en_reg_out_7_0,  lo);
    chk("en_reg_out_15_8", idx, en_reg_out_15_8, hi);
    chk("en_reg_pwm_7_0",  idx, en_reg_pwm_7_0,  plo);
    chk("en_reg_pwm_15_8", idx, en_reg_pwm_15_8, phi);
    chk("pwm_duty_cycle",  idx, pwm_duty_cycle,  duty);
  endtask

  task automatic chk_status(input int idx, input logic err, input logic [7:0] cnt,
                            input logic bsy, input logic r0, input logic r1);
    chk("addr_err", idx, addr_err, err);
    chk("err_cnt",  idx, err_cnt,  cnt);
    chk("busy",     idx, busy,     bsy);
    chk("p0_ready", idx, p0_ready, r0);
    chk("p1_ready", idx, p1_ready, r1);
  endtask

  task automatic idle_inputs();
    p0_valid = 1'b0; p0_addr = '0; p0_data = '0;
    p1_valid = 1'b0; p1_addr = '0; p1_data = '0;
    clr_err  = 1'b0;
  endtask

  // Inputs change at negedge; outputs are sampled at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // single write; reset; contended same address; two-port streaming; bad write
    tbl[0]  = mk(0, 1, 7'h04, 8'h80, 0, 7'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'd0, 1, 1, 1);
    tbl[1]  = mk(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 0, 8'd0, 0, 1, 1);
    tbl[2]  = mk(1, 1, 7'h00, 8'hAA, 1, 7'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'd0, 1, 1, 1);
    tbl[3]  = mk(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'd0, 1, 1, 1);
    tbl[4]  = mk(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'd0, 0, 1, 1);
    tbl[5]  = mk(0, 1, 7'h02, 8'h01, 1, 7'h03, 8'h11, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'd0, 1, 1, 1);
    tbl[6]  = mk(0, 1, 7'h02, 8'h02, 1, 7'h03, 8'h12, 8'h55, 8'h00, 8'h01, 8'h00, 8'h00, 0, 8'd0, 1, 1, 0);
    tbl[7]  = mk(0, 1, 7'h02, 8'h03, 1, 7'h03, 8'h13, 8'h55, 8'h00, 8'h01, 8'h11, 8'h00, 0, 8'd0, 1, 0, 1);
    tbl[8]  = mk(0, 1, 7'h02, 8'h04, 1, 7'h03, 8'h13, 8'h55, 8'h00, 8'h02, 8'h11, 8'h00, 0, 8'd0, 1, 1, 0);
    tbl[9]  = mk(0, 1, 7'h02, 8'h04, 1, 7'h03, 8'h14, 8'h55, 8'h00, 8'h02, 8'h12, 8'h00, 0, 8'd0, 1, 0, 1);
    tbl[10] = mk(0, 0, 7'h00, 8'h00, 1, 7'h03, 8'h14, 8'h55, 8'h00, 8'h03, 8'h12, 8'h00, 0, 8'd0, 1, 1, 0);
    tbl[11] = mk(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 8'h55, 8'h00, 8'h03, 8'h13, 8'h00, 0, 8'd0, 1, 1, 1);
    tbl[12] = mk(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 8'h55, 8'h00, 8'h04, 8'h13, 8'h00, 0, 8'd0, 1, 1, 1);
    tbl[13] = mk(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 8'h55, 8'h00, 8'h04, 8'h14, 8'h00, 0, 8'd0, 0, 1, 1);
    tbl[14] = mk(0, 0, 7'h00, 8'h00, 1, 7'h05, 8'h99, 8'h55, 8'h00, 8'h04, 8'h14, 8'h00, 0, 8'd0, 1, 1, 1);
    tbl[15] = mk(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 8'h55, 8'h00, 8'h04, 8'h14, 8'h00, 1, 8'd1, 0, 1, 1);

    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_bank(-1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk_status(-1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < NVEC; i++) begin
      if (tbl[i].rst) do_reset();
      p0_valid = tbl[i].v0; p0_addr = tbl[i].a0; p0_data = tbl[i].d0;
      p1_valid = tbl[i].v1; p1_addr = tbl[i].a1; p1_data = tbl[i].d1;
      clr_err  = 1'b0;
      step();
      chk_bank(i, tbl[i].e_lo, tbl[i].e_hi, tbl[i].e_plo, tbl[i].e_phi, tbl[i].e_duty);
      chk_status(i, tbl[i].e_err, tbl[i].e_cnt, tbl[i].e_busy, tbl[i].e_r0, tbl[i].e_r1);
    end
    idle_inputs();

    // Stream bad writes on port 1; commits trail pushes by one cycle.
    p1_valid = 1'b1; p1_addr = 7'h7F; p1_data = 8'h3C;
    for (int i = 0; i < 254; i++) step();
    chk("err_cnt_254", 100, err_cnt, 8'd254);
    chk("p1_ready_stream", 100, p1_ready, 1'b1);
    for (int i = 0; i < 46; i++) step();
    idle_inputs();
    step();
    step();
    chk("err_cnt_sat", 101, err_cnt, 8'd255);
    chk("addr_err_sat", 101, addr_err, 1'b1);
    chk("busy_sat", 101, busy, 1'b0);
    chk_bank(101, 8'h55, 8'h00, 8'h04, 8'h14, 8'h00);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("addr_err_clr", 102, addr_err, 1'b0);
    chk("err_cnt_clr", 102, err_cnt, 8'd0);

    // Reset while both FIFOs hold a queued write.
    p0_valid = 1'b1; p0_addr = 7'h00; p0_data = 8'h77;
    p1_valid = 1'b1; p1_addr = 7'h04; p1_data = 8'h66;
    step();
    chk("busy_queued", 103, busy, 1'b1);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk_bank(104, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk_status(104, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    step();
    chk_bank(105, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("busy_after_rst", 105, busy, 1'b0);

    // Clear colliding with a bad-address commit.
    p1_valid = 1'b1; p1_addr = 7'h05; p1_data = 8'h01;
    step();
    step();
    step();
    chk("err_cnt_pre_clr", 106, err_cnt, 8'd2);
    idle_inputs();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("addr_err_coincide", 107, addr_err, 1'b1);
    chk("err_cnt_coincide", 107, err_cnt, 8'd1);
    step();
    chk("err_cnt_hold", 108, err_cnt, 8'd1);
    chk("busy_final", 108, busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
